// File: rtl/seq_det_ctrl_if.sv
// Word and result handshakes between a producer/consumer and seq_det_ctrl.
// The slave modport is the controller side; master is the word source / result sink.
interface seq_det_ctrl_if #(
  parameter int unsigned WORD_W = 12,
  parameter int unsigned CNT_W  = 4
);
  logic              word_valid_i;
  logic [WORD_W-1:0] word_i;
  logic              word_ready_o;
  logic              clr_mode_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [CNT_W-1:0]  res_count_o;
  logic              res_hit_o;

  modport slave (
    input  word_valid_i, word_i, clr_mode_i, res_ready_i,
    output word_ready_o, res_valid_o, res_count_o, res_hit_o
  );

  modport master (
    output word_valid_i, word_i, clr_mode_i, res_ready_i,
    input  word_ready_o, res_valid_o, res_count_o, res_hit_o
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Serialises parallel words MSB-first into the 1110_1101_1011 detector and
// reports, per word, how many detector hits landed inside that word's window.
module seq_det_ctrl #(
  parameter int unsigned WORD_W  = 12,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned DET_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  seq_det_ctrl_if.slave    bus,
  output logic             x_o,
  output logic             x_en_o,
  output logic             det_rst_o,
  input  logic             det_i,
  output logic             busy_o
);

  localparam int unsigned BIT_W = $clog2((WORD_W > DET_LAT) ? WORD_W : DET_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_e;

  state_e             state_q;
  logic [WORD_W-1:0]  word_q;
  logic [BIT_W-1:0]   bitcnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               x_q;
  logic               x_en_q;
  logic               det_rst_q;
  logic               ready_q;
  logic               busy_q;
  logic               res_valid_q;
  logic [CNT_W-1:0]   res_count_q;
  logic               res_hit_q;
  logic               x_en_dly;

  // x_en delayed by the detector latency marks where det_i belongs to this word
  generate
    if (DET_LAT == 0) begin : g_no_lat
      assign x_en_dly = x_en_q;
    end else begin : g_lat
      logic [DET_LAT-1:0] en_sr_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          en_sr_q <= '0;
        end else begin
          en_sr_q <= (en_sr_q << 1) | DET_LAT'(x_en_q);
        end
      end
      assign x_en_dly = en_sr_q[DET_LAT-1];
    end
  endgenerate

  // Saturating in-window hit count
  always_comb begin
    cnt_d = cnt_q;
    if (x_en_dly && det_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      bitcnt_q    <= '0;
      cnt_q       <= '0;
      x_q         <= 1'b0;
      x_en_q      <= 1'b0;
      det_rst_q   <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      res_hit_q   <= 1'b0;
    end else begin
      x_q       <= 1'b0;
      x_en_q    <= 1'b0;
      det_rst_q <= 1'b0;
      cnt_q     <= cnt_d;
      unique case (state_q)
        IDLE: begin
          if (bus.word_valid_i && ready_q) begin
            word_q  <= bus.word_i;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.clr_mode_i) begin
              state_q   <= CLEAR;
              det_rst_q <= 1'b1;
            end else begin
              state_q  <= SHIFT;
              x_q      <= bus.word_i[WORD_W-1];
              x_en_q   <= 1'b1;
              bitcnt_q <= BIT_W'(WORD_W - 1);
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        CLEAR: begin
          state_q  <= SHIFT;
          x_q      <= word_q[WORD_W-1];
          x_en_q   <= 1'b1;
          bitcnt_q <= BIT_W'(WORD_W - 1);
        end
        SHIFT: begin
          if (bitcnt_q != '0) begin
            bitcnt_q <= bitcnt_q - BIT_W'(1);
            x_q      <= word_q[bitcnt_q - BIT_W'(1)];
            x_en_q   <= 1'b1;
          end else if (DET_LAT == 0) begin
            state_q     <= REPORT;
            res_valid_q <= 1'b1;
            res_count_q <= cnt_d;
            res_hit_q   <= (cnt_d != '0);
          end else begin
            state_q  <= DRAIN;
            bitcnt_q <= BIT_W'(DET_LAT - 1);
          end
        end
        DRAIN: begin
          if (bitcnt_q != '0) begin
            bitcnt_q <= bitcnt_q - BIT_W'(1);
          end else begin
            state_q     <= REPORT;
            res_valid_q <= 1'b1;
            res_count_q <= cnt_d;
            res_hit_q   <= (cnt_d != '0);
          end
        end
        REPORT: begin
          if (bus.res_ready_i) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_o              = x_q;
  assign x_en_o           = x_en_q;
  assign det_rst_o        = det_rst_q;
  assign busy_o           = busy_q;
  assign bus.word_ready_o = ready_q;
  assign bus.res_valid_o  = res_valid_q;
  assign bus.res_count_o  = res_count_q;
  assign bus.res_hit_o    = res_hit_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench: three controllers (DET_LAT 0/1/3) with detector models,
// plus a CNT_W=3 controller driven by a stub det for saturation/windowing.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        word_valid;
  logic [11:0] word;
  logic        clr_mode;
  logic        res_ready;
  logic        sat_all;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  genvar k;
  for (k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned LAT = (k == 0) ? 0 : (k == 1) ? 1 : 3;
    seq_det_ctrl_if #(.WORD_W(12), .CNT_W(4)) bus ();
    logic        x, x_en, det_rst, det, busy, m_now;
    logic [11:0] sh_q;
    logic [2:0]  m_sr_q;

    assign bus.word_valid_i = word_valid;
    assign bus.word_i       = word;
    assign bus.clr_mode_i   = clr_mode;
    assign bus.res_ready_i  = res_ready;

    seq_det_ctrl #(.WORD_W(12), .CNT_W(4), .DET_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset), .bus(bus), .x_o(x), .x_en_o(x_en),
      .det_rst_o(det_rst), .det_i(det), .busy_o(busy)
    );

    // Reference detector: match on the 12 most recent bits, output delayed LAT cycles
    assign m_now = x_en && ({sh_q[10:0], x} == 12'hEDB);
    always @(posedge clk) begin
      if (reset || det_rst) begin
        sh_q   <= '0;
        m_sr_q <= '0;
      end else begin
        if (x_en) sh_q <= {sh_q[10:0], x};
        m_sr_q <= {m_sr_q[1:0], m_now};
      end
    end
    if (LAT == 0) begin : g_d0
      assign det = m_now;
    end else begin : g_dn
      assign det = m_sr_q[LAT-1];
    end
  end

  seq_det_ctrl_if #(.WORD_W(12), .CNT_W(3)) sbus ();
  logic s_x, s_x_en, s_det_rst, s_det, s_busy;
  assign sbus.word_valid_i = word_valid;
  assign sbus.word_i       = word;
  assign sbus.clr_mode_i   = clr_mode;
  assign sbus.res_ready_i  = res_ready;
  assign s_det = sat_all | ~s_busy | s_det_rst | sbus.res_valid_o;

  seq_det_ctrl #(.WORD_W(12), .CNT_W(3), .DET_LAT(1)) u_sat (
    .clk(clk), .reset(reset), .bus(sbus), .x_o(s_x), .x_en_o(s_x_en),
    .det_rst_o(s_det_rst), .det_i(s_det), .busy_o(s_busy)
  );

  logic [2:0] rv;
  logic [3:0] rc [3];
  logic       all_ready;
  assign rv[0] = g_dut[0].bus.res_valid_o;
  assign rv[1] = g_dut[1].bus.res_valid_o;
  assign rv[2] = g_dut[2].bus.res_valid_o;
  assign rc[0] = g_dut[0].bus.res_count_o;
  assign rc[1] = g_dut[1].bus.res_count_o;
  assign rc[2] = g_dut[2].bus.res_count_o;
  assign all_ready = g_dut[0].bus.word_ready_o & g_dut[1].bus.word_ready_o &
                     g_dut[2].bus.word_ready_o & sbus.word_ready_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_all_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (all_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ready_timeout", 32'(ok), 32'd1);
  endtask

  // Returns at the negedge of cycle T+1, T being the accept cycle
  task automatic send(input logic [11:0] w, input logic c);
    wait_all_ready();
    word_valid = 1'b1;
    word       = w;
    clr_mode   = c;
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input bit use_sat, input int ec);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (use_sat ? sbus.res_valid_o : rv[1]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    if (use_sat) begin
      chk({tag, "_cnt"}, 32'(sbus.res_count_o), 32'(ec));
      chk({tag, "_hit"}, 32'(sbus.res_hit_o), 32'(ec != 0));
    end else begin
      chk({tag, "_cnt"}, 32'(rc[1]), 32'(ec));
      chk({tag, "_hit"}, 32'(g_dut[1].bus.res_hit_o), 32'(ec != 0));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  logic [11:0] pat;
  bit          seen;

  initial begin
    reset = 1'b1; word_valid = 1'b0; word = '0; clr_mode = 1'b0;
    res_ready = 1'b1; sat_all = 1'b0; pat = 12'hEDB;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(g_dut[1].bus.word_ready_o), 32'd0);
    chk("rst_busy", 32'(g_dut[1].busy), 32'd0);
    chk("rst_xen", 32'(g_dut[1].x_en), 32'd0);
    chk("rst_valid", 32'(rv[1]), 32'd0);
    chk("rst_detrst", 32'(g_dut[1].det_rst), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(g_dut[1].bus.word_ready_o), 32'd1);

    // Single match with clear
    send(12'hEDB, 1'b1);
    chk("t1_detrst", 32'(g_dut[1].det_rst), 32'd1);
    chk("t1_clr_xen", 32'(g_dut[1].x_en), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t1_xen", 32'(g_dut[1].x_en), 32'd1);
      chk("t1_bit", 32'(g_dut[1].x), 32'(pat[11-i]));
    end
    @(negedge clk);
    chk("t1_drain_valid", 32'(rv[1]), 32'd0);
    chk("t1_drain_xen", 32'(g_dut[1].x_en), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(rv[1]), 32'd1);
    chk("t1_cnt", 32'(rc[1]), 32'd1);
    chk("t1_hit", 32'(g_dut[1].bus.res_hit_o), 32'd1);
    @(negedge clk);
    chk("t1_valid_drop", 32'(rv[1]), 32'd0);
    chk("t1_ready_back", 32'(g_dut[1].bus.word_ready_o), 32'd1);

    // Pattern split over two words
    send(12'h00E, 1'b0); wait_res("t2_a", 1'b0, 0);
    send(12'hDB0, 1'b0); wait_res("t2_b", 1'b0, 1);
    send(12'h00E, 1'b1); wait_res("t2_c", 1'b0, 0);
    send(12'hDB0, 1'b1); wait_res("t2_d", 1'b0, 0);

    // Saturation, then det only outside the window
    sat_all = 1'b1;
    send(12'hEDB, 1'b1); wait_res("t3_sat", 1'b1, 7);
    sat_all = 1'b0;
    send(12'hEDB, 1'b1); wait_res("t3_out", 1'b1, 0);

    // Result backpressure with a word waiting
    wait_all_ready();
    res_ready = 1'b0;
    send(12'hEDB, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rv[1]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t4_seen", 32'(seen), 32'd1);
    word_valid = 1'b1; word = 12'h00E; clr_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(rv[1]), 32'd1);
      chk("t4_hold_cnt", 32'(rc[1]), 32'd1);
      chk("t4_hold_hit", 32'(g_dut[1].bus.res_hit_o), 32'd1);
      chk("t4_hold_ready", 32'(g_dut[1].bus.word_ready_o), 32'd0);
      chk("t4_hold_xen", 32'(g_dut[1].x_en), 32'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_after_valid", 32'(rv[1]), 32'd0);
    chk("t4_after_ready", 32'(g_dut[1].bus.word_ready_o), 32'd1);
    chk("t4_after_busy", 32'(g_dut[1].busy), 32'd0);
    @(negedge clk);
    word_valid = 1'b0;
    chk("t4_accept_detrst", 32'(g_dut[1].det_rst), 32'd1);
    chk("t4_accept_busy", 32'(g_dut[1].busy), 32'd1);
    wait_res("t4_next", 1'b0, 0);

    // Reset while shifting bit 6
    send(12'hEDB, 1'b0);
    repeat (5) @(negedge clk);
    chk("t5_bit6", 32'(g_dut[1].x), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_x", 32'(g_dut[1].x), 32'd0);
    chk("t5_xen", 32'(g_dut[1].x_en), 32'd0);
    chk("t5_busy", 32'(g_dut[1].busy), 32'd0);
    chk("t5_valid", 32'(rv[1]), 32'd0);
    chk("t5_ready", 32'(g_dut[1].bus.word_ready_o), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_ready_after", 32'(g_dut[1].bus.word_ready_o), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rv[1]) seen = 1'b1;
      @(negedge clk);
    end
    chk("t5_no_result", 32'(seen), 32'd0);
    send(12'hEDB, 1'b0); wait_res("t5_next", 1'b0, 1);

    // Latency sweep across DET_LAT 0/1/3
    do_reset();
    send(12'hEDB, 1'b0);
    for (int rel = 1; rel <= 18; rel++) begin
      for (int j = 0; j < 3; j++) begin
        int lat;
        lat = (j == 0) ? 0 : (j == 1) ? 1 : 3;
        chk("t6_valid", 32'(rv[j]), 32'(rel == 13 + lat));
        if (rel == 13 + lat) chk("t6_cnt", 32'(rc[j]), 32'd1);
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
